// File: rtl/fc_output_drain.sv
// Shadow-register drain for the FC fold accumulator: snapshots the sum vector on
// capture, requantizes it and streams it out BEAT lanes at a time over valid/ready.
// Optional build macro DRAIN_OFFSET_EN: subtract OFFSET with a ReLU floor before the shift.
module fc_output_drain #(
  parameter  int N_LANE = 55,
  parameter  int SUM_WD = 16,
  parameter  int OUT_WD = 8,
  parameter  int BEAT   = 5,
  parameter  int SHIFT  = 4,
  parameter  int OFFSET = 0,
  localparam int NBEAT  = N_LANE / BEAT,
  localparam int BW     = (NBEAT > 1) ? $clog2(NBEAT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture,
  input  logic [N_LANE*SUM_WD-1:0] sum,
  output logic                     cap_ready,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BEAT*OUT_WD-1:0]   out_data,
  output logic [BW-1:0]            out_beat,
  output logic                     out_last,
  output logic                     overrun,
  input  logic                     clr_err
);

  if ((N_LANE % BEAT) != 0 || SHIFT < 0 || SHIFT >= SUM_WD || OUT_WD >= SUM_WD ||
      OFFSET < 0 || OFFSET >= (2 ** SUM_WD)) begin : g_bad_cfg
    $error("fc_output_drain: illegal parameter combination");
  end

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [SUM_WD-1:0] SAT_LIM = SUM_WD'((1 << OUT_WD) - 1);

  state_t                     r_state, w_state_nxt;
  logic [BW-1:0]              r_beat_idx, w_beat_nxt;
  logic [N_LANE*SUM_WD-1:0]   r_shadow;
  logic                       r_overrun;
  logic                       w_fire, w_last, w_cap_ready, w_accept;

  function automatic logic [OUT_WD-1:0] requant(input logic [SUM_WD-1:0] s);
    logic [SUM_WD-1:0] v;
`ifdef DRAIN_OFFSET_EN
    logic [SUM_WD:0] d;
    // Both operands are below 2^SUM_WD, so the extra top bit is the sign of s - OFFSET.
    d = {1'b0, s} - (SUM_WD + 1)'(OFFSET);
    if (d[SUM_WD]) return '0;
    v = d[SUM_WD-1:0] >> SHIFT;
`else
    v = s >> SHIFT;
`endif
    return (v > SAT_LIM) ? {OUT_WD{1'b1}} : v[OUT_WD-1:0];
  endfunction

  assign out_valid   = (r_state == S_STREAM);
  assign busy        = (r_state != S_IDLE);
  assign w_last      = (r_state == S_STREAM) && (r_beat_idx == BW'(NBEAT - 1));
  assign w_fire      = out_valid && out_ready;
  // A capture on the final handshake is accepted so the next frame follows with no bubble.
  assign w_cap_ready = (r_state == S_IDLE) || (w_fire && w_last);
  assign w_accept    = capture && w_cap_ready;
  assign cap_ready   = w_cap_ready;
  assign out_last    = w_last;
  assign out_beat    = r_beat_idx;
  assign overrun     = r_overrun;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_idx;
    if (w_accept) begin
      w_state_nxt = S_STREAM;
      w_beat_nxt  = '0;
    end else if (w_fire) begin
      if (w_last) begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = '0;
      end else begin
        w_beat_nxt  = r_beat_idx + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_beat_idx <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_idx <= w_beat_nxt;
      if (capture && !w_cap_ready) r_overrun <= 1'b1;
      else if (clr_err)            r_overrun <= 1'b0;
    end
  end

  // NOTE: the shadow bank is reset so a stale frame can never reach out_data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_shadow <= '0;
    else if (w_accept) r_shadow <= sum;
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < BEAT; k++) begin
      out_data[k*OUT_WD +: OUT_WD] =
        requant(r_shadow[(int'(r_beat_idx) * BEAT + k) * SUM_WD +: SUM_WD]);
    end
  end

endmodule

// File: tb/tb_fc_output_drain.sv
// Self-checking bench for fc_output_drain: directed steps, beat scoreboard, immediate assertions.
module tb_fc_output_drain;

  localparam int N_LANE = 55;
  localparam int SUM_WD = 16;
  localparam int OUT_WD = 8;
  localparam int BEAT   = 5;
  localparam int SHIFT  = 4;
  localparam int OFFSET = 100;
  localparam int NBEAT  = N_LANE / BEAT;
  localparam int BW     = $clog2(NBEAT);

  logic                     clk, rst_n, capture, out_ready, clr_err;
  logic [N_LANE*SUM_WD-1:0] sum;
  logic                     cap_ready, busy, out_valid, out_last, overrun;
  logic [BEAT*OUT_WD-1:0]   out_data;
  logic [BW-1:0]            out_beat;

  fc_output_drain #(
    .N_LANE(N_LANE), .SUM_WD(SUM_WD), .OUT_WD(OUT_WD),
    .BEAT(BEAT), .SHIFT(SHIFT), .OFFSET(OFFSET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .capture(capture), .sum(sum),
    .cap_ready(cap_ready), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beat(out_beat), .out_last(out_last),
    .overrun(overrun), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [BEAT*OUT_WD-1:0] data;
    logic [BW-1:0]          beat;
    logic                   last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  logic  m_overrun = 1'b0;
  int    lanes[N_LANE];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference requantizer written with plain integer arithmetic.
  function automatic int model_lane(input int s);
    int d;
`ifdef DRAIN_OFFSET_EN
    d = s - OFFSET;
    if (d < 0) return 0;
`else
    d = s;
`endif
    d = d / (1 << SHIFT);
    return (d > 255) ? 255 : d;
  endfunction

  task automatic set_lanes(input int base, input int stepv);
    for (int j = 0; j < N_LANE; j++) begin
      lanes[j] = base + j * stepv;
      sum[j*SUM_WD +: SUM_WD] = SUM_WD'(lanes[j]);
    end
  endtask

  task automatic push_frame();
    beat_t e;
    for (int b = 0; b < NBEAT; b++) begin
      for (int k = 0; k < BEAT; k++)
        e.data[k*OUT_WD +: OUT_WD] = OUT_WD'(model_lane(lanes[b*BEAT+k]));
      e.beat = BW'(b);
      e.last = (b == NBEAT - 1);
      sb.push_back(e);
    end
  endtask

  // One clock cycle: drive inputs just after a negedge, check, then advance to the next negedge.
  task automatic step(input logic cap, input logic rdy, input logic clr);
    logic  exp_cr;
    beat_t f;
    capture = cap; out_ready = rdy; clr_err = clr;
    #1;
    chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
    chk("busy", 64'(busy), 64'(sb.size() > 0));
    chk("overrun", 64'(overrun), 64'(m_overrun));
    exp_cr = (sb.size() == 0) || (rdy && sb.size() == 1);
    chk("cap_ready", 64'(cap_ready), 64'(exp_cr));
    if (sb.size() > 0) begin
      f = sb[0];
      chk("out_data", 64'(out_data), 64'(f.data));
      chk("out_beat", 64'(out_beat), 64'(f.beat));
      chk("out_last", 64'(out_last), 64'(f.last));
      if (rdy) void'(sb.pop_front());
    end else begin
      chk("idle_last", 64'(out_last), 64'(0));
    end
    if (cap && exp_cr) push_frame();
    if (cap && !exp_cr) m_overrun = 1'b1;
    else if (clr)       m_overrun = 1'b0;
    @(posedge clk);
    @(negedge clk);
    capture = 1'b0; clr_err = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 64'(sb.size() == 0), 64'(1));
    step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; capture = 1'b0; out_ready = 1'b0; clr_err = 1'b0; sum = '0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cap_ready", 64'(cap_ready), 64'(1));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_beat", 64'(out_beat), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);

    // Ramp frame, lane j = j*16, full-rate consumer.
    set_lanes(0, 16);
    step(1'b1, 1'b1, 1'b0);
`ifndef DRAIN_OFFSET_EN
    #1 chk("ramp_beat0", 64'(out_data), 64'h04_03_02_01_00);
`endif
    drain(20);

    // Saturation and plain shift values.
    set_lanes(16'hFFFF, 0); step(1'b1, 1'b1, 1'b0); drain(20);
    set_lanes(16'h0FF0, 0); step(1'b1, 1'b1, 1'b0); drain(20);
    set_lanes(16'h00F0, 0); step(1'b1, 1'b1, 1'b0); drain(20);

    // Offset / ReLU-floor values (plain shift when the option is off).
    set_lanes(50, 0);          step(1'b1, 1'b1, 1'b0); drain(20);
    set_lanes(100 + 16*7, 0);  step(1'b1, 1'b1, 1'b0); drain(20);

    // Back-pressure: ready pattern 1,0,0 repeating.
    set_lanes(3, 17);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60 && sb.size() > 0; i++)
      step(1'b0, (i % 3) == 0, 1'b0);
    chk("bp_done", 64'(sb.size() == 0), 64'(1));
    step(1'b0, 1'b1, 1'b0);

    // Back-to-back frames: second capture on the final handshake.
    set_lanes(0, 16);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && sb.size() > 1; i++) step(1'b0, 1'b1, 1'b0);
    set_lanes(32, 0);
    step(1'b1, 1'b1, 1'b0);
    drain(20);

    // Overrun: capture at beat 3 is dropped, original data continues.
    set_lanes(0, 16);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && sb.size() > 0 && sb[0].beat != BW'(3); i++)
      step(1'b0, 1'b1, 1'b0);
    set_lanes(7, 1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    drain(20);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stream.
    set_lanes(0, 16);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && sb.size() > 0 && sb[0].beat != BW'(5); i++)
      step(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_beat", 64'(out_beat), 64'(0));
    chk("mid_rst_cap_ready", 64'(cap_ready), 64'(1));
    sb.delete();
    m_overrun = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
